inv_key_expansion: RTL and testbench



---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_sbox.sv | 28 ++
 rtl/inv_key_expansion.sv | 106 ++++++++++
 tb/tb_inv_key_expansion.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-schedule FSM encoding and Rcon helper
package aes_pkg;

  localparam int AES_NR = 10;
  localparam logic [7:0] AES_RCON_LAST = 8'h36;
  localparam int AES_KEY_W = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } kexp_state_e;

  // Inverse of xtime in GF(2^8): steps the Rcon sequence backwards (36,1B,80,...,02,01).
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    logic [7:0] t;
    t = r ^ 8'h1B;
    return r[0] ? ((t >> 1) | 8'h80) : (r >> 1);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational single-byte forward AES S-box
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/inv_key_expansion.sv
// rtl/inv_key_expansion.sv - reverse AES-128 key schedule, round keys NR..0 on a valid/ready stream; option INV_KEYEXP_ZEROIZE_EN
module inv_key_expansion
  import aes_pkg::*;
#(
  parameter int         NR        = AES_NR,
  parameter logic [7:0] RCON_LAST = AES_RCON_LAST
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 rk_ready,
  output logic                 rk_valid,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic [3:0]           rk_round,
  output logic                 busy,
  output logic                 done
);

  kexp_state_e state_q, state_d;
  logic [7:0] rcon_q, rcon_d;
  logic [AES_KEY_W-1:0] rk_out_d;
  logic [3:0] rk_round_d;
  logic done_d;
  logic beat;

  logic [AES_WORD_W-1:0] k0, k1, k2, k3;
  logic [AES_WORD_W-1:0] p0, p1, p2, p3;
  logic [AES_WORD_W-1:0] rot_p3, sub_p3;
  logic [AES_KEY_W-1:0] prev_key;

  assign {k0, k1, k2, k3} = rk_out;

  // Undo the forward recurrence w[i] = w[i-1] ^ w[i-4], last word first.
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;
  assign rot_p3 = {p3[23:0], p3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_p3[8*i +: 8]),
      .dout (sub_p3[8*i +: 8])
    );
  end

  assign p0 = k0 ^ sub_p3 ^ {rcon_q, 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  assign beat = rk_valid & rk_ready;

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out;
    rk_round_d = rk_round;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_out_d   = key_in;
          rk_round_d = 4'(NR);
          rcon_d     = RCON_LAST;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (beat) begin
          if (rk_round != 4'd0) begin
            rk_out_d   = prev_key;
            rk_round_d = rk_round - 4'd1;
            rcon_d     = inv_xtime(rcon_q);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef INV_KEYEXP_ZEROIZE_EN
            rk_out_d = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      rk_out   <= '0;
      rk_round <= 4'd0;
      rcon_q   <= RCON_LAST;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rk_out   <= rk_out_d;
      rk_round <= rk_round_d;
      rcon_q   <= rcon_d;
      rk_valid <= (state_d == RUN);
      busy     <= (state_d == RUN);
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// tb/tb_inv_key_expansion.sv - directed-vector bench for inv_key_expansion
module tb_inv_key_expansion;

  logic         Clk;
  logic         Rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] a1_keys [11];
  logic [127:0] zero_keys [11];

  inv_key_expansion dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_key(input bit zero_tbl, input int idx);
    return zero_tbl ? zero_keys[idx] : a1_keys[idx];
  endfunction

  // mode 0: ready held, 1: random ready, 2: start pulse at round 5, 3: reset at round 6
  task automatic run_seq(input bit zero_tbl, input int mode);
    int idx;
    int dones;
    logic [127:0] key;
    idx   = 10;
    dones = 0;
    key   = exp_key(zero_tbl, 10);
    @(negedge Clk);
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge Clk);
    start  = 1'b0;
    key_in = ~key;
    for (int cyc = 0; cyc < 300 && idx >= 0; cyc++) begin
      if (mode == 1) rk_ready = 1'($urandom_range(0, 1));
      if (mode == 2) start = (idx == 5);
      if (mode == 3 && idx == 6) begin
        Rst = 1'b0;
        #1;
        check("rst_valid", {127'd0, rk_valid}, 128'd0);
        check("rst_out", rk_out, 128'd0);
        check("rst_round", {124'd0, rk_round}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge Clk);
          check("rst_done", {127'd0, done}, 128'd0);
        end
        Rst = 1'b1;
        @(negedge Clk);
        check("post_rst_done", {127'd0, done}, 128'd0);
        check("post_rst_busy", {127'd0, busy}, 128'd0);
        return;
      end
      if (done) dones++;
      check("valid", {127'd0, rk_valid}, 128'd1);
      check("busy", {127'd0, busy}, 128'd1);
      check("round", {124'd0, rk_round}, 128'(idx));
      check("key", rk_out, exp_key(zero_tbl, idx));
      if (rk_ready) idx--;
      @(negedge Clk);
    end
    start = 1'b0;
    check("timeout", 128'(idx), 128'hffffffff_ffffffff_ffffffff_ffffffff);
    check("early_done", 128'(dones), 128'd0);
    check("done", {127'd0, done}, 128'd1);
    check("end_valid", {127'd0, rk_valid}, 128'd0);
    check("end_busy", {127'd0, busy}, 128'd0);
`ifdef INV_KEYEXP_ZEROIZE_EN
    check("end_out", rk_out, 128'd0);
`else
    check("end_out", rk_out, exp_key(zero_tbl, 0));
`endif
    @(negedge Clk);
    check("done_pulse", {127'd0, done}, 128'd0);
`ifdef INV_KEYEXP_ZEROIZE_EN
    check("hold_out", rk_out, 128'd0);
`else
    check("hold_out", rk_out, exp_key(zero_tbl, 0));
`endif
  endtask

  initial begin
    a1_keys[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    a1_keys[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    a1_keys[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    a1_keys[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    a1_keys[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    a1_keys[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    a1_keys[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    a1_keys[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    a1_keys[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    a1_keys[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    a1_keys[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    zero_keys[0]  = 128'h00000000_00000000_00000000_00000000;
    zero_keys[1]  = 128'h62636363_62636363_62636363_62636363;
    zero_keys[2]  = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
    zero_keys[3]  = 128'h90973450_696ccffa_f2f45733_0b0fac99;
    zero_keys[4]  = 128'hee06da7b_876a1581_759e42b2_7e91ee2b;
    zero_keys[5]  = 128'h7f2e2b88_f8443e09_8dda7cbb_f34b9290;
    zero_keys[6]  = 128'hec614b85_1425758c_99ff0937_6ab49ba7;
    zero_keys[7]  = 128'h21751787_3550620b_acaf6b3c_c61bf09b;
    zero_keys[8]  = 128'h0ef90333_3ba96138_97060a04_511dfa9f;
    zero_keys[9]  = 128'hb1d4d8e2_8a7db9da_1d7bb3de_4c664941;
    zero_keys[10] = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    Rst      = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_valid", {127'd0, rk_valid}, 128'd0);
    check("reset_out", rk_out, 128'd0);
    check("reset_round", {124'd0, rk_round}, 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    Rst = 1'b1;

    run_seq(1'b0, 0);
    run_seq(1'b0, 1);
    run_seq(1'b0, 2);
    run_seq(1'b0, 3);
    run_seq(1'b0, 0);
    run_seq(1'b1, 0);
    run_seq(1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
